hdb3_decode: RTL and testbench

HDB3_DECODE -- requirements
Module: hdb3_decode

---
 rtl/hdb3_decode.sv | 67 ++++++
 tb/tb_hdb3_decode.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdb3_decode.sv
// HDB3 line decoder: ternary symbols in, NRZ bits out through a fixed 4-stage
// pipeline so that a violation pulse can erase the three symbols before it.
module hdb3_decode (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_hdb3_code,
    output logic       o_data,
    output logic       o_valid,
    output logic       o_err
);

    // stage_q[0] is s1 (newest), stage_q[3] is s4 (drives o_data)
    logic [3:0] stage_q, stage_d;
    logic       pol_q, pol_d;      // 1 = last mark positive, 0 = negative
    logic [2:0] zrun_q, zrun_d;
    logic [2:0] fill_q, fill_d;
    logic       err_q, err_d;

    logic is_zero;
    logic is_illegal;
    logic is_pulse;
    logic sym_pos;
    logic is_v;
    logic is_mark;

    always_comb begin
        is_zero    = (i_hdb3_code == 2'b00);
        is_illegal = (i_hdb3_code == 2'b10);
        is_pulse   = i_hdb3_code[0];
        sym_pos    = ~i_hdb3_code[1];
        is_v       = is_pulse && (sym_pos == pol_q);
        is_mark    = is_pulse && (sym_pos != pol_q);

        pol_d   = is_pulse ? sym_pos : pol_q;
        // A violation erases itself and the three symbols still in flight
        stage_d = is_v ? 4'b0000 : {stage_q[2:0], is_mark};

        if (is_zero)
            zrun_d = (zrun_q == 3'd7) ? 3'd7 : zrun_q + 3'd1;
        else
            zrun_d = 3'd0;

        err_d  = is_illegal || (is_zero && (zrun_q >= 3'd3));
        fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stage_q <= 4'b0000;
            pol_q   <= 1'b0;
            zrun_q  <= 3'd0;
            fill_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            pol_q   <= pol_d;
            zrun_q  <= zrun_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    assign o_data  = stage_q[3];
    assign o_valid = (fill_q == 3'd4);
    assign o_err   = err_q;

endmodule

// File: tb/tb_hdb3_decode.sv
// Self-checking bench for hdb3_decode: directed vector tables, hand-written
// corner sequences and random symbols checked against a behavioural model.
module tb_hdb3_decode;

    logic       i_clk;
    logic       i_rst;
    logic [1:0] i_hdb3_code;
    logic       o_data;
    logic       o_valid;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    hdb3_decode dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_hdb3_code (i_hdb3_code),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_err       (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0] code;
        logic       data;
        logic       valid;
        logic       err;
    } vec_t;

    // Behavioural model: list of decoded bits per symbol since reset
    bit m_bits[$];
    int m_pol;      // 1 = positive, 0 = negative
    int m_zrun;
    int m_nsym;
    logic exp_data, exp_valid, exp_err;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pol  = 0;
        m_zrun = 0;
        m_nsym = 0;
    endtask

    task automatic model_step(input logic [1:0] code);
        int pol_sym;
        exp_err = 1'b0;
        if (code == 2'b00) begin
            if (m_zrun >= 3) exp_err = 1'b1;
            m_zrun++;
            m_bits.push_back(1'b0);
        end else if (code == 2'b10) begin
            exp_err = 1'b1;
            m_zrun  = 0;
            m_bits.push_back(1'b0);
        end else begin
            m_zrun  = 0;
            pol_sym = (code == 2'b01) ? 1 : 0;
            if (pol_sym == m_pol) begin
                for (int j = m_bits.size() - 3; j < m_bits.size(); j++)
                    if (j >= 0) m_bits[j] = 1'b0;
                m_bits.push_back(1'b0);
            end else begin
                m_bits.push_back(1'b1);
            end
            m_pol = pol_sym;
        end
        m_nsym++;
        exp_valid = (m_nsym >= 4);
        exp_data  = (m_nsym >= 4) ? m_bits[m_nsym - 4] : 1'b0;
    endtask

    // Drive one symbol, clock it in, compare against the model.
    task automatic step(input logic [1:0] code, input string tag);
        i_hdb3_code = code;
        @(posedge i_clk);
        #1;
        model_step(code);
        check({tag, ".data"},  o_data,  exp_data);
        check({tag, ".valid"}, o_valid, exp_valid);
        check({tag, ".err"},   o_err,   exp_err);
    endtask

    task automatic do_reset();
        i_hdb3_code = 2'b00;
        i_rst = 1'b1;
        @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        model_reset();
        check("rst.data",  o_data,  1'b0);
        check("rst.valid", o_valid, 1'b0);
        check("rst.err",   o_err,   1'b0);
    endtask

    vec_t tbl_000v[9];
    vec_t tbl_b00v[9];

    initial begin
        tbl_000v[0] = '{2'b01, 1'b0, 1'b0, 1'b0};
        tbl_000v[1] = '{2'b00, 1'b0, 1'b0, 1'b0};
        tbl_000v[2] = '{2'b00, 1'b0, 1'b0, 1'b0};
        tbl_000v[3] = '{2'b00, 1'b1, 1'b1, 1'b0};
        tbl_000v[4] = '{2'b01, 1'b0, 1'b1, 1'b0};
        tbl_000v[5] = '{2'b11, 1'b0, 1'b1, 1'b0};
        tbl_000v[6] = '{2'b00, 1'b0, 1'b1, 1'b0};
        tbl_000v[7] = '{2'b00, 1'b0, 1'b1, 1'b0};
        tbl_000v[8] = '{2'b00, 1'b1, 1'b1, 1'b0};

        tbl_b00v[0] = '{2'b01, 1'b0, 1'b0, 1'b0};
        tbl_b00v[1] = '{2'b11, 1'b0, 1'b0, 1'b0};
        tbl_b00v[2] = '{2'b01, 1'b0, 1'b0, 1'b0};
        tbl_b00v[3] = '{2'b00, 1'b1, 1'b1, 1'b0};
        tbl_b00v[4] = '{2'b00, 1'b1, 1'b1, 1'b0};
        tbl_b00v[5] = '{2'b01, 1'b0, 1'b1, 1'b0};
        tbl_b00v[6] = '{2'b00, 1'b0, 1'b1, 1'b0};
        tbl_b00v[7] = '{2'b00, 1'b0, 1'b1, 1'b0};
        tbl_b00v[8] = '{2'b00, 1'b0, 1'b1, 1'b0};

        i_rst = 1'b1;
        i_hdb3_code = 2'b00;
        model_reset();
        #12;
        check("async_rst.data",  o_data,  1'b0);
        check("async_rst.valid", o_valid, 1'b0);
        check("async_rst.err",   o_err,   1'b0);

        // 000V table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl_000v[i].code, "000v_model");
            check("000v.data",  o_data,  tbl_000v[i].data);
            check("000v.valid", o_valid, tbl_000v[i].valid);
            check("000v.err",   o_err,   tbl_000v[i].err);
        end

        // B00V table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl_b00v[i].code, "b00v_model");
            check("b00v.data",  o_data,  tbl_b00v[i].data);
            check("b00v.valid", o_valid, tbl_b00v[i].valid);
            check("b00v.err",   o_err,   tbl_b00v[i].err);
        end

        // Illegal symbol: polarity kept, following 11 is a mark
        do_reset();
        step(2'b01, "ill");
        check("ill.err_before", o_err, 1'b0);
        step(2'b10, "ill");
        check("ill.err_pulse", o_err, 1'b1);
        step(2'b11, "ill");
        check("ill.err_clear", o_err, 1'b0);
        step(2'b00, "ill");
        check("ill.data0", o_data, 1'b1);
        step(2'b00, "ill");
        check("ill.data1", o_data, 1'b0);
        step(2'b00, "ill");
        check("ill.data2", o_data, 1'b1);

        // Zero run: errors on 4th, 5th, 6th zero
        do_reset();
        step(2'b01, "zrun");
        for (int i = 1; i <= 6; i++) begin
            step(2'b00, "zrun");
            check("zrun.err", o_err, (i >= 4) ? 1'b1 : 1'b0);
        end
        step(2'b11, "zrun");
        check("zrun.err_end", o_err, 1'b0);

        // Mid-stream reset with ones in every stage
        do_reset();
        step(2'b01, "mid");
        step(2'b11, "mid");
        step(2'b01, "mid");
        step(2'b11, "mid");
        check("mid.full_data", o_data, 1'b1);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid.rst_data",  o_data,  1'b0);
        check("mid.rst_valid", o_valid, 1'b0);
        check("mid.rst_err",   o_err,   1'b0);
        #3;
        i_rst = 1'b0;
        model_reset();
        step(2'b11, "mid_post");
        step(2'b01, "mid_post");
        step(2'b00, "mid_post");
        step(2'b00, "mid_post");
        check("mid.first_v", o_data, 1'b0);
        step(2'b00, "mid_post");
        check("mid.mark", o_data, 1'b1);

        // Random symbols, occasional resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [1:0] c;
            int r;
            r = $urandom_range(0, 99);
            if (r < 40)      c = 2'b00;
            else if (r < 68) c = 2'b01;
            else if (r < 96) c = 2'b11;
            else             c = 2'b10;
            if ($urandom_range(0, 199) == 0) do_reset();
            step(c, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
